// File: rtl/fetch_stage.sv
// fetch_stage: in-order instruction fetch front end. Issues sequential fetch
// requests, tags each response with its request PC from an in-order PC queue,
// buffers responses for the decoder, and discards stale responses after a
// redirect.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN adds a sticky misalign_err
// output that flags redirects whose target has non-zero low bits.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0100_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clock,
    input  logic        reset_n,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic        misalign_err,
`endif
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    // state | meaning
    // BOOT  | one idle cycle after reset, no requests
    // RUN   | normal fetch, responses go into the buffer
    // FLUSH | dropping stale responses left over from a redirect
    localparam logic [1:0] BOOT  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] FLUSH = 2'd2;

    localparam int CW  = $clog2(DEPTH + 1);
    localparam int CW1 = CW + 1;
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW:0]   DEPTH_W = CW1'(DEPTH);
    localparam logic [PW-1:0] LAST_IX = PW'(DEPTH - 1);

    logic [1:0]    state;
    logic [31:0]   fetch_pc;
    logic [CW-1:0] inflight;
    logic [CW-1:0] discard_cnt;
    logic [CW-1:0] fifo_cnt;
    logic [PW-1:0] fifo_rd;
    logic [PW-1:0] fifo_wr;
    logic [31:0]   fifo_data [DEPTH];
    logic [31:0]   fifo_pc   [DEPTH];
    logic [PW-1:0] pcq_rd;
    logic [PW-1:0] pcq_wr;
    logic [31:0]   pcq       [DEPTH];

    logic          pop;
    logic          push;
    logic          req_fire;
    logic          flush;
    logic [CW:0]   occupancy;
    logic [CW-1:0] inflight_next;
    logic [CW-1:0] discard_dec;
    logic [31:0]   target_pc;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_IX) ? '0 : p + PW'(1);
    endfunction

    assign inst_valid = (fifo_cnt != '0) && !redirect_valid;
    assign inst_data  = fifo_data[fifo_rd];
    assign inst_pc    = fifo_pc[fifo_rd];
    assign pop        = inst_valid && inst_ready;

    // Request gating: in-flight plus buffered must stay below DEPTH; a pop this
    // cycle frees a slot so a full buffer can still issue a new request.
    always_comb begin
        occupancy      = {1'b0, inflight} + {1'b0, fifo_cnt} - {{CW{1'b0}}, pop};
        imem_req_valid = (state == RUN) && (occupancy < DEPTH_W);
        imem_req_addr  = fetch_pc;
        req_fire       = imem_req_valid && imem_req_ready;
        flush          = redirect_valid && (state != BOOT);
        push           = imem_rsp_valid && (state == RUN) && !redirect_valid;
        inflight_next  = inflight + CW'(req_fire) - CW'(imem_rsp_valid);
        discard_dec    = discard_cnt - CW'(imem_rsp_valid);
        target_pc      = redirect_pc & 32'hFFFF_FFFC;
    end

    // Control FSM, fetch PC and stale-response counter. On a redirect every
    // request still in flight after this edge (including one accepted now)
    // is stale.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= BOOT;
            fetch_pc    <= RESET_PC;
            discard_cnt <= '0;
        end else begin
            case (state)
                BOOT: begin
                    state <= RUN;
                    if (redirect_valid) fetch_pc <= target_pc;
                end
                RUN: begin
                    if (redirect_valid) begin
                        fetch_pc    <= target_pc;
                        discard_cnt <= inflight_next;
                        state       <= (inflight_next != '0) ? FLUSH : RUN;
                    end else if (req_fire) begin
                        fetch_pc <= fetch_pc + 32'd4;
                    end
                end
                FLUSH: begin
                    if (redirect_valid) begin
                        fetch_pc    <= target_pc;
                        discard_cnt <= inflight_next;
                        state       <= (inflight_next != '0) ? FLUSH : RUN;
                    end else begin
                        discard_cnt <= discard_dec;
                        if (discard_dec == '0) state <= RUN;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

    // In-flight counter and in-order PC queue; every response retires the
    // oldest entry whether it is kept or dropped.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inflight <= '0;
            pcq_rd   <= '0;
            pcq_wr   <= '0;
            for (int i = 0; i < DEPTH; i++) pcq[i] <= '0;
        end else begin
            inflight <= inflight_next;
            if (req_fire) begin
                pcq[pcq_wr] <= fetch_pc;
                pcq_wr      <= ptr_inc(pcq_wr);
            end
            if (imem_rsp_valid) pcq_rd <= ptr_inc(pcq_rd);
        end
    end

    // Instruction buffer toward the decoder; cleared wholesale on a redirect.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fifo_cnt <= '0;
            fifo_rd  <= '0;
            fifo_wr  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_pc[i]   <= '0;
            end
        end else if (flush) begin
            fifo_cnt <= '0;
            fifo_rd  <= '0;
            fifo_wr  <= '0;
        end else begin
            if (push) begin
                fifo_data[fifo_wr] <= imem_rsp_data;
                fifo_pc[fifo_wr]   <= pcq[pcq_rd];
                fifo_wr            <= ptr_inc(fifo_wr);
            end
            if (pop) fifo_rd <= ptr_inc(fifo_rd);
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
        end
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    // Sticky flag for redirect targets that are not word aligned.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            misalign_err <= 1'b0;
        end else if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
            misalign_err <= 1'b1;
        end
    end
`endif

endmodule
